// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LDUSE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } pipe_state_e;

   localparam int unsigned DEF_LOADUSE_BUBBLES = 1;
   localparam int unsigned DEF_DRAIN_CYCLES    = 3;
   localparam int unsigned PERF_W              = 16;

   // Width needed to hold the larger of the bubble and drain counts.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EX status in, pipeline-register enables/flushes and status out.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_BITS = 3
);
   logic [REG_BITS-1:0] id_rs;
   logic                id_rs_valid;
   logic [REG_BITS-1:0] id_rt;
   logic                id_rt_valid;
   logic                id_halt;
   logic [REG_BITS-1:0] ex_rd;
   logic                ex_mem_read;
   logic                ex_reg_write;
   logic                ex_redirect;
   logic                imem_busy;
   logic                dmem_busy;
   logic                pc_en;
   logic                ifid_en;
   logic                ifid_flush;
   logic                idex_en;
   logic                idex_flush;
   logic                exmem_en;
   logic                halted;
   logic [1:0]          state_o;
   logic [15:0]         stall_cycles;
   logic [15:0]         flush_events;

   modport master (
      output id_rs, id_rs_valid, id_rt, id_rt_valid, id_halt,
             ex_rd, ex_mem_read, ex_reg_write, ex_redirect, imem_busy, dmem_busy,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             halted, state_o, stall_cycles, flush_events
   );

   modport slave (
      input  id_rs, id_rs_valid, id_rt, id_rt_valid, id_halt,
             ex_rd, ex_mem_read, ex_reg_write, ex_redirect, imem_busy, dmem_busy,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             halted, state_o, stall_cycles, flush_events
   );
endinterface

// File: rtl/pipe_hazard_ctrl_haz_dep_cmp.sv
// Load-use dependency detect: ID sources against a pending load destination in EX.
module haz_dep_cmp #(
   parameter int unsigned REG_BITS = 3
) (
   input  logic [REG_BITS-1:0] id_rs,
   input  logic                id_rs_valid,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_rt_valid,
   input  logic [REG_BITS-1:0] ex_rd,
   input  logic                ex_mem_read,
   input  logic                ex_reg_write,
   output logic                hz
);
   always_comb begin
      hz = ex_mem_read & ex_reg_write &
           ((id_rs_valid & (id_rs == ex_rd)) | (id_rt_valid & (id_rt == ex_rd)));
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, redirect, memory stalls, HALT drain.
// Optional performance counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_BITS        = 3,
   parameter int unsigned LOADUSE_BUBBLES = DEF_LOADUSE_BUBBLES,
   parameter int unsigned DRAIN_CYCLES    = DEF_DRAIN_CYCLES
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = cnt_width(LOADUSE_BUBBLES, DRAIN_CYCLES);

   pipe_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hz;
   logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

   haz_dep_cmp #(.REG_BITS(REG_BITS)) u_dep (
      .id_rs        (bus.id_rs),
      .id_rs_valid  (bus.id_rs_valid),
      .id_rt        (bus.id_rt),
      .id_rt_valid  (bus.id_rt_valid),
      .ex_rd        (bus.ex_rd),
      .ex_mem_read  (bus.ex_mem_read),
      .ex_reg_write (bus.ex_reg_write),
      .hz           (hz)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_en    = 1'b1;
      idex_flush = 1'b0;
      exmem_en   = 1'b1;
      if (rst || state_q == ST_HALTED || bus.dmem_busy) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (state_q == ST_DRAIN) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         cnt_d      = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) state_d = ST_HALTED;
      end else if (bus.ex_redirect) begin
         // Redirect squashes a pending load-use stall and any HALT in ID.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = ST_RUN;
         cnt_d      = '0;
      end else if (state_q == ST_LDUSE || hz) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         if (state_q == ST_LDUSE) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
         end else if (LOADUSE_BUBBLES > 1) begin
            state_d = ST_LDUSE;
            cnt_d   = CNT_W'(LOADUSE_BUBBLES - 1);
         end
      end else if (bus.imem_busy) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end else if (bus.id_halt) begin
         state_d = ST_DRAIN;
         cnt_d   = CNT_W'(DRAIN_CYCLES);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc_en      = pc_en;
   assign bus.ifid_en    = ifid_en;
   assign bus.ifid_flush = ifid_flush;
   assign bus.idex_en    = idex_en;
   assign bus.idex_flush = idex_flush;
   assign bus.exmem_en   = exmem_en;
   assign bus.halted     = (state_q == ST_HALTED);
   assign bus.state_o    = state_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic              redir_taken;

   always_comb begin
      // Count only redirects actually acted on, not ones frozen by dmem_busy.
      redir_taken = bus.ex_redirect & ~bus.dmem_busy &
                    (state_q == ST_RUN || state_q == ST_LDUSE);
      stall_d = stall_q;
      flush_d = flush_q;
      if (!pc_en && state_q != ST_HALTED && stall_q != '1) stall_d = stall_q + PERF_W'(1);
      if (redir_taken && flush_q != '1) flush_d = flush_q + PERF_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign bus.stall_cycles = stall_q;
   assign bus.flush_events = flush_q;
`else
   assign bus.stall_cycles = '0;
   assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two instances (1 and 2 load-use bubbles) share one stimulus stream.
module tb_pipe_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_rs, id_rt, ex_rd;
   logic       id_rs_valid, id_rt_valid, id_halt;
   logic       ex_mem_read, ex_reg_write, ex_redirect, imem_busy, dmem_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_BITS(3)) ia ();
   pipe_hazard_ctrl_if #(.REG_BITS(3)) ib ();

   assign ia.id_rs = id_rs;               assign ib.id_rs = id_rs;
   assign ia.id_rs_valid = id_rs_valid;   assign ib.id_rs_valid = id_rs_valid;
   assign ia.id_rt = id_rt;               assign ib.id_rt = id_rt;
   assign ia.id_rt_valid = id_rt_valid;   assign ib.id_rt_valid = id_rt_valid;
   assign ia.id_halt = id_halt;           assign ib.id_halt = id_halt;
   assign ia.ex_rd = ex_rd;               assign ib.ex_rd = ex_rd;
   assign ia.ex_mem_read = ex_mem_read;   assign ib.ex_mem_read = ex_mem_read;
   assign ia.ex_reg_write = ex_reg_write; assign ib.ex_reg_write = ex_reg_write;
   assign ia.ex_redirect = ex_redirect;   assign ib.ex_redirect = ex_redirect;
   assign ia.imem_busy = imem_busy;       assign ib.imem_busy = imem_busy;
   assign ia.dmem_busy = dmem_busy;       assign ib.dmem_busy = dmem_busy;

   pipe_hazard_ctrl #(.REG_BITS(3), .LOADUSE_BUBBLES(1), .DRAIN_CYCLES(3)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave));
   pipe_hazard_ctrl #(.REG_BITS(3), .LOADUSE_BUBBLES(2), .DRAIN_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave));

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted, state_o}
   logic [8:0] oa, ob;
   assign oa = {ia.pc_en, ia.ifid_en, ia.ifid_flush, ia.idex_en, ia.idex_flush,
                ia.exmem_en, ia.halted, ia.state_o};
   assign ob = {ib.pc_en, ib.ifid_en, ib.ifid_flush, ib.idex_en, ib.idex_flush,
                ib.exmem_en, ib.halted, ib.state_o};

   localparam logic [8:0] O_RST     = 9'b000000000;
   localparam logic [8:0] O_RUN     = 9'b110101000;
   localparam logic [8:0] O_BUB     = 9'b000111000;
   localparam logic [8:0] O_BUB_L   = 9'b000111001;
   localparam logic [8:0] O_REDIR   = 9'b111111000;
   localparam logic [8:0] O_REDIR_L = 9'b111111001;
   localparam logic [8:0] O_FRZ     = 9'b000000000;
   localparam logic [8:0] O_FRZ_L   = 9'b000000001;
   localparam logic [8:0] O_IMEM    = 9'b011101000;
   localparam logic [8:0] O_DRAIN   = 9'b011111010;
   localparam logic [8:0] O_HALT    = 9'b000000111;

`ifdef PIPE_HAZARD_PERF_EN
   localparam logic [15:0] EXP_STALL = 16'd10;
   localparam logic [15:0] EXP_FLUSH = 16'd2;
`else
   localparam logic [15:0] EXP_STALL = 16'd0;
   localparam logic [15:0] EXP_FLUSH = 16'd0;
`endif

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_rs_valid = 1'b0; id_rt_valid = 1'b0; id_halt = 1'b0;
      ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_redirect = 1'b0;
      imem_busy = 1'b0; dmem_busy = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_rs3();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd3;
      id_rs = 3'd3; id_rs_valid = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      clr();
      tick(); tick();
      chk("reset_a", oa, O_RST);
      chk("reset_b", ob, O_RST);
      chk("reset_stall", ia.stall_cycles, 16'd0);
      chk("reset_flush", ia.flush_events, 16'd0);
      rst = 1'b0; #1;
      chk("idle_a", oa, O_RUN);

      // Load-use on rs
      tick(); load_use_rs3(); #1;
      chk("lu_a", oa, O_BUB);
      chk("lu_b", ob, O_BUB);
      tick(); clr(); #1;
      chk("lu_a_after", oa, O_RUN);
      chk("lu_b_second", ob, O_BUB_L);
      tick();
      chk("lu_b_after", ob, O_RUN);

      // rt path and non-hazard variants (combinational only)
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd5;
      id_rs = 3'd5; id_rs_valid = 1'b0; id_rt = 3'd5; id_rt_valid = 1'b1; #1;
      chk("lu_rt", oa, O_BUB);
      id_rt_valid = 1'b0; #1;
      chk("rt_invalid", oa, O_RUN);
      id_rt_valid = 1'b1; ex_reg_write = 1'b0; #1;
      chk("no_regwrite", oa, O_RUN);
      ex_reg_write = 1'b1; ex_rd = 3'd4; #1;
      chk("rd_differs", oa, O_RUN);
      clr();

      // Hazard with redirect in the same cycle
      load_use_rs3(); ex_redirect = 1'b1; #1;
      chk("hz_redir_a", oa, O_REDIR);
      chk("hz_redir_b", ob, O_REDIR);
      tick(); clr(); #1;
      chk("hz_redir_b_next", ob, O_RUN);

      // dmem_busy freeze during LDUSE
      load_use_rs3(); tick(); clr(); dmem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("dmem_frz_b", ob, O_FRZ_L);
         chk("dmem_frz_a", oa, O_FRZ);
         tick();
      end
      dmem_busy = 1'b0; #1;
      chk("dmem_resume_b", ob, O_BUB_L);
      tick();
      chk("dmem_exit_b", ob, O_RUN);

      // Redirect while in LDUSE
      load_use_rs3(); tick(); clr(); ex_redirect = 1'b1; #1;
      chk("ldu_redir_b", ob, O_REDIR_L);
      tick(); clr(); #1;
      chk("ldu_redir_exit_b", ob, O_RUN);

      // imem_busy, and its priority below load-use
      imem_busy = 1'b1; #1;
      chk("imem_a", oa, O_IMEM);
      load_use_rs3(); #1;
      chk("imem_vs_hz_a", oa, O_BUB);
      clr();

      // Redirect cancels halt
      id_halt = 1'b1; ex_redirect = 1'b1; #1;
      chk("halt_redir_a", oa, O_REDIR);
      tick(); clr(); #1;
      chk("halt_cancelled_a", oa, O_RUN);

      // Performance counters from a clean reset
      rst = 1'b1; tick(); rst = 1'b0;
      imem_busy = 1'b1;
      repeat (10) tick();
      imem_busy = 1'b0; ex_redirect = 1'b1;
      repeat (2) tick();
      clr(); #1;
      chk("perf_stall", ia.stall_cycles, EXP_STALL);
      chk("perf_flush", ia.flush_events, EXP_FLUSH);

      // HALT drain
      id_halt = 1'b1; #1;
      chk("halt_issue_a", oa, O_RUN);
      tick(); clr(); #1;
      chk("drain1_a", oa, O_DRAIN);
      tick();
      chk("drain2_a", oa, O_DRAIN);
      tick();
      chk("drain3_a", oa, O_DRAIN);
      tick();
      chk("halted_a", oa, O_HALT);
      ex_redirect = 1'b1; imem_busy = 1'b1; #1;
      chk("halted_ignores_a", oa, O_HALT);
      tick();
      chk("halted_hold_a", oa, O_HALT);
      clr();
      rst = 1'b1; #1;
      chk("halted_rst_a", oa, O_RST);
      tick(); rst = 1'b0; #1;
      chk("post_halt_run_a", oa, O_RUN);

      // Reset mid-drain
      id_halt = 1'b1; tick(); clr(); #1;
      chk("drain_mid_a", oa, O_DRAIN);
      rst = 1'b1; #1;
      chk("drain_rst_a", oa, O_RST);
      tick(); rst = 1'b0; #1;
      chk("drain_rst_run_a", oa, O_RUN);
      tick();
      chk("drain_rst_stay_a", oa, O_RUN);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
